ddr_write_splitter: RTL

//  Sits directly downstream of the arbitrator write port. Takes one 768-bit

---
 rtl/ddr_write_splitter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ddr_write_splitter.sv
// Splits one BEATS*DATA_W write request from the arbitrator into BEATS native
// UI data beats and commands, each command issued only after its data beat.
module ddr_write_splitter #(
  parameter int ADDR_W    = 31,
  parameter int DATA_W    = 256,
  parameter int BEATS     = 3,
  parameter int ADDR_STEP = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      phy_init_done,
  input  logic                      write_in,
  input  logic [ADDR_W-1:0]         w_address_in,
  input  logic [BEATS*DATA_W-1:0]   w_data_in,
  output logic                      w_busy,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_W-1:0]         app_addr,
  input  logic                      app_rdy,
  output logic                      app_wdf_wren,
  output logic [DATA_W-1:0]         app_wdf_data,
  output logic                      app_wdf_end,
  output logic [DATA_W/8-1:0]       app_wdf_mask,
  input  logic                      app_wdf_rdy
);

  localparam int REQ_W = BEATS * DATA_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0]  BEATS_C = CNT_W'(BEATS);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(ADDR_STEP);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   dcnt_r;
  logic [CNT_W-1:0]   dcnt_nxt_s;
  logic [CNT_W-1:0]   ccnt_r;
  logic [CNT_W-1:0]   ccnt_nxt_s;
  logic [ADDR_W-1:0]  base_r;
  logic [REQ_W-1:0]   data_r;
  logic               w_busy_r;
  logic               accept_s;

  assign accept_s     = (state_r == IDLE) && write_in && !w_busy_r;
  assign w_busy       = w_busy_r;
  assign app_cmd      = 3'b000;
  assign app_wdf_mask = {(DATA_W/8){1'b0}};

  // Next-state, counter advance and UI output decode from the registered state
  always_comb begin
    state_nxt_s  = state_r;
    dcnt_nxt_s   = dcnt_r;
    ccnt_nxt_s   = ccnt_r;
    app_en       = 1'b0;
    app_addr     = {ADDR_W{1'b0}};
    app_wdf_wren = 1'b0;
    app_wdf_data = {DATA_W{1'b0}};
    app_wdf_end  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = XFER;
          dcnt_nxt_s  = {CNT_W{1'b0}};
          ccnt_nxt_s  = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        app_wdf_wren = (dcnt_r < BEATS_C);
        for (int k = 0; k < BEATS; k++) begin
          app_wdf_data = (dcnt_r == CNT_W'(k)) ? data_r[k*DATA_W +: DATA_W] : app_wdf_data;
        end
        app_wdf_end = app_wdf_wren;
        // A command may only trail data beats that have already been accepted
        app_en   = (ccnt_r < dcnt_r);
        app_addr = base_r + ADDR_W'(ccnt_r) * STEP_C;
        if (app_wdf_wren && app_wdf_rdy) begin
          dcnt_nxt_s = dcnt_r + CNT_W'(1);
        end else begin
          dcnt_nxt_s = dcnt_r;
        end
        if (app_en && app_rdy) begin
          ccnt_nxt_s = ccnt_r + CNT_W'(1);
        end else begin
          ccnt_nxt_s = ccnt_r;
        end
        if (ccnt_r == BEATS_C) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, beat counters and the registered busy flag back to the arbitrator
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      dcnt_r   <= {CNT_W{1'b0}};
      ccnt_r   <= {CNT_W{1'b0}};
      w_busy_r <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      dcnt_r   <= dcnt_nxt_s;
      ccnt_r   <= ccnt_nxt_s;
      w_busy_r <= (state_nxt_s == IDLE) ? ~phy_init_done : 1'b1;
    end
  end

  // Request capture: base address and the full data word on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r <= {ADDR_W{1'b0}};
      data_r <= {REQ_W{1'b0}};
    end else if (accept_s) begin
      base_r <= w_address_in;
      data_r <= w_data_in;
    end else begin
      base_r <= base_r;
      data_r <= data_r;
    end
  end

endmodule
